// File: rtl/uart_defs.sv
// Shared definitions for the memory-mapped UART transmitter:
// register offsets, STATUS bit positions, FSM encoding, DIVISOR width.
package uart_defs;

    // Register offsets, decoded from addr_i[3:2]
    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_DIVISOR = 2'd2;

    // STATUS register bit positions
    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;

    // DIVISOR register width
    localparam int DIV_W = 16;

    // Transmit FSM encoding (PARITY is only reachable with UART_TX_PARITY_EN)
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } tx_state_e;

    // A stored divisor of 0 behaves as 1 so a bit always lasts at least one cycle
    function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
        return (d == '0) ? DIV_W'(1) : d;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO for the UART transmitter. Pointers carry one extra
// wrap bit so full and empty are told apart without a separate counter.
// A push while full is ignored, even when a pop happens on the same edge.
module uart_tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [7:0]               wdata_i,
    input  logic                     pop_i,
    output logic [7:0]               rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        do_push;
    logic        do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointer advance
    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
    end

    // Pointer registers, cleared by reset so queued data is discarded
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents need no reset because the pointers gate them
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped UART transmitter: bus decode, STATUS/DIVISOR registers,
// FIFO, and the 8N1 serializer. Defining UART_TX_PARITY_EN adds an even
// parity bit after the data bits (11-bit frame).
module uart_tx_periph
    import uart_defs::*;
#(
    parameter int CLK_DIV    = 434,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        txd_o,
    output logic        int_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // Bus decode
    logic wr_txdata, wr_div, rd_status;
    assign wr_txdata = ce_i &&  we_i && (addr_i[3:2] == REG_TXDATA);
    assign wr_div    = ce_i &&  we_i && (addr_i[3:2] == REG_DIVISOR);
    assign rd_status = ce_i && !we_i && (addr_i[3:2] == REG_STATUS);

    // Unused address/lane bits gathered in one place
    logic unused_bits;
    assign unused_bits = ^{addr_i[31:4], addr_i[1:0], sel_i[3:2], data_i[31:16]};

    // FIFO
    logic          fifo_full, fifo_empty, fifo_pop;
    logic [7:0]    fifo_rdata;
    logic [CW-1:0] fifo_count;

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (wr_txdata),
        .wdata_i (data_i[7:0]),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // State
    tx_state_e        state_q, state_d;
    logic [DIV_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             ovf_q, ovf_d;
    logic             txd_q, txd_d;
    logic             int_q, int_d;
`ifdef UART_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic [DIV_W-1:0] div_eff;
    logic             bit_done;
    assign div_eff  = eff_div(div_q);
    assign bit_done = (bit_cnt_q <= DIV_W'(1));

    // Transmit FSM: next state, bit counter, bit index, shifter and FIFO pop
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        fifo_pop  = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shift_d   = fifo_rdata;
                    bit_cnt_d = div_eff;
                    state_d   = S_START;
`ifdef UART_TX_PARITY_EN
                    parity_d  = ^fifo_rdata;
`endif
                end
            end
            S_START: begin
                if (bit_done) begin
                    bit_cnt_d = div_eff;
                    bit_idx_d = 3'd0;
                    state_d   = S_DATA;
                end else begin
                    bit_cnt_d = bit_cnt_q - DIV_W'(1);
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    bit_cnt_d = div_eff;
                    shift_d   = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - DIV_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_done) begin
                    bit_cnt_d = div_eff;
                    state_d   = S_STOP;
                end else begin
                    bit_cnt_d = bit_cnt_q - DIV_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (bit_done) begin
                    state_d = S_IDLE;
                end else begin
                    bit_cnt_d = bit_cnt_q - DIV_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Registered outputs: line level follows the current state, interrupt
    // reports an empty FIFO with an idle shifter
    always_comb begin
        txd_d = 1'b1;
        case (state_q)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: txd_d = parity_q;
`endif
            default:  txd_d = 1'b1;
        endcase
        int_d = fifo_empty && (state_q == S_IDLE);
    end

    // Register updates: DIVISOR byte lanes and sticky overflow (set beats clear)
    always_comb begin
        div_d = div_q;
        if (wr_div && sel_i[0]) div_d[7:0]  = data_i[7:0];
        if (wr_div && sel_i[1]) div_d[15:8] = data_i[15:8];
        ovf_d = ovf_q;
        if (wr_txdata && fifo_full) ovf_d = 1'b1;
        else if (rd_status)         ovf_d = 1'b0;
    end

    // State registers, asynchronously reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            div_q     <= DIV_W'(CLK_DIV);
            ovf_q     <= 1'b0;
            txd_q     <= 1'b1;
            int_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            div_q     <= div_d;
            ovf_q     <= ovf_d;
            txd_q     <= txd_d;
            int_q     <= int_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign txd_o = txd_q;
    assign int_o = int_q;

    // STATUS word; count field saturates at 15 for deeper FIFOs
    logic [31:0] status_w;
    logic [31:0] count_ext;
    always_comb begin
        count_ext                       = 32'(fifo_count);
        status_w                        = '0;
        status_w[ST_FULL]               = fifo_full;
        status_w[ST_EMPTY]              = fifo_empty;
        status_w[ST_BUSY]               = (state_q != S_IDLE);
        status_w[ST_OVF]                = ovf_q;
        status_w[ST_CNT_LSB+3:ST_CNT_LSB] = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];
    end

    // Combinational read mux, zero when not selected
    always_comb begin
        data_o = '0;
        if (ce_i) begin
            case (addr_i[3:2])
                REG_STATUS:  data_o = status_w;
                REG_DIVISOR: data_o = {16'h0, div_q};
                default:     data_o = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_periph.sv
// Self-checking bench for uart_tx_periph. Expected serial streams come from
// a frame-level model: two idle samples after the write, then per byte a
// start bit, eight data bits LSB first, optional even parity and a stop bit,
// each lasting max(DIVISOR,1) cycles, with one idle cycle between frames.
module tb_uart_tx_periph;

    localparam logic [1:0] R_TX   = 2'd0;
    localparam logic [1:0] R_ST   = 2'd1;
    localparam logic [1:0] R_DIV  = 2'd2;
    localparam logic [1:0] R_NONE = 2'd3;

    logic        clk = 1'b1;
    logic        rst = 1'b0;
    logic        ce_i = 1'b0;
    logic        we_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [3:0]  sel_i = '0;
    logic [31:0] data_i = '0;
    logic [31:0] data_o;
    logic        txd_o;
    logic        int_o;

    int total = 0;
    int bad   = 0;

    // Clock: posedges at multiples of 10 ns
    always #5 clk = ~clk;

    uart_tx_periph dut (
        .clk    (clk),
        .rst    (rst),
        .ce_i   (ce_i),
        .we_i   (we_i),
        .addr_i (addr_i),
        .sel_i  (sel_i),
        .data_i (data_i),
        .data_o (data_o),
        .txd_o  (txd_o),
        .int_o  (int_o)
    );

    // Line recorder, sampled on the falling edge
    logic rec_en = 1'b0;
    logic obs_txd[$];
    logic obs_int[$];
    always @(negedge clk) begin
        if (rec_en) begin
            obs_txd.push_back(txd_o);
            obs_int.push_back(int_o);
        end
    end

    // Scoreboard
    logic       exp_q[$];
    logic       exp_int_q[$];
    logic [7:0] tx_bytes[$];

    // Driver tasks
    task automatic bus_write(input logic [1:0] r, input logic [31:0] d, input logic [3:0] s);
        ce_i   = 1'b1;
        we_i   = 1'b1;
        addr_i = {28'($urandom), r, 2'($urandom)};
        data_i = d;
        sel_i  = s;
        @(posedge clk);
        #1;
        ce_i   = 1'b0;
        we_i   = 1'b0;
        data_i = '0;
        sel_i  = '0;
    endtask

    task automatic bus_read(input logic [1:0] r, output logic [31:0] d);
        ce_i   = 1'b1;
        we_i   = 1'b0;
        addr_i = {28'($urandom), r, 2'($urandom)};
        #2;
        d = data_o;
        @(posedge clk);
        #1;
        ce_i = 1'b0;
    endtask

    // Reference model: build expected line and interrupt streams from tx_bytes
    task automatic build_expected(input int div);
        int eff;
        int busy_len;
        logic [7:0] b;
        eff = (div == 0) ? 1 : div;
        exp_q.delete();
        exp_int_q.delete();
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b1);
        for (int i = 0; i < tx_bytes.size(); i++) begin
            b = tx_bytes[i];
            if (i > 0) exp_q.push_back(1'b1);
            for (int c = 0; c < eff; c++) exp_q.push_back(1'b0);
            for (int k = 0; k < 8; k++)
                for (int c = 0; c < eff; c++) exp_q.push_back(b[k]);
`ifdef UART_TX_PARITY_EN
            for (int c = 0; c < eff; c++) exp_q.push_back(^b);
`endif
            for (int c = 0; c < eff; c++) exp_q.push_back(1'b1);
        end
        busy_len = exp_q.size();
        for (int c = 0; c < 6; c++) exp_q.push_back(1'b1);
        for (int k = 0; k < exp_q.size(); k++)
            exp_int_q.push_back((k == 0) || (k >= busy_len));
    endtask

    task automatic start_record;
        obs_txd.delete();
        obs_int.delete();
        rec_en = 1'b1;
    endtask

    task automatic check_stream(input string name);
        int guard;
        int idx;
        guard = 0;
        while (obs_txd.size() < exp_q.size() && guard < exp_q.size() + 50) begin
            @(posedge clk);
            guard++;
        end
        #1;
        rec_en = 1'b0;
        total++;
        if (obs_txd.size() < exp_q.size()) begin
            bad++;
            $display("FAIL %s timeout: got %0d samples, need %0d", name, obs_txd.size(), exp_q.size());
            return;
        end
        idx = -1;
        for (int k = 0; k < exp_q.size(); k++)
            if (idx < 0 && obs_txd[k] !== exp_q[k]) idx = k;
        if (idx >= 0) begin
            bad++;
            $display("FAIL %s txd sample %0d: got %b, expected %b", name, idx, obs_txd[idx], exp_q[idx]);
        end
        total++;
        idx = -1;
        for (int k = 0; k < exp_int_q.size(); k++)
            if (idx < 0 && obs_int[k] !== exp_int_q[k]) idx = k;
        if (idx >= 0) begin
            bad++;
            $display("FAIL %s int sample %0d: got %b, expected %b", name, idx, obs_int[idx], exp_int_q[idx]);
        end
    endtask

    // Send tx_bytes back-to-back at the given divisor and check the line
    task automatic send_and_check(input int div, input string name);
        logic [31:0] rd;
        bus_write(R_DIV, 32'(div), 4'b0011);
        build_expected(div);
        for (int i = 0; i < tx_bytes.size(); i++) begin
            bus_write(R_TX, {24'($urandom), tx_bytes[i]}, 4'($urandom));
            if (i == 0) start_record();
        end
        check_stream(name);
        bus_read(R_ST, rd);
        total++;
        if (rd !== 32'h2) begin
            bad++;
            $display("FAIL %s status_after: got %h, expected %h", name, rd, 32'h2);
        end
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        #100;
        total++;
        if (txd_o !== 1'b1) begin bad++; $display("FAIL reset_txd: got %b, expected 1", txd_o); end
        total++;
        if (int_o !== 1'b1) begin bad++; $display("FAIL reset_int: got %b, expected 1", int_o); end
        total++;
        if (data_o !== 32'h0) begin bad++; $display("FAIL reset_data_o: got %h, expected 0", data_o); end
        #95;
        rst = 1'b1;
        @(posedge clk);
        #1;
        bus_read(R_ST, rd);
        total++;
        if (rd !== 32'h2) begin bad++; $display("FAIL reset_status: got %h, expected %h", rd, 32'h2); end
        bus_read(R_DIV, rd);
        total++;
        if (rd !== 32'd434) begin bad++; $display("FAIL reset_divisor: got %0d, expected 434", rd); end
        bus_read(R_TX, rd);
        total++;
        if (rd !== 32'h0) begin bad++; $display("FAIL txdata_read: got %h, expected 0", rd); end
        bus_read(R_NONE, rd);
        total++;
        if (rd !== 32'h0) begin bad++; $display("FAIL reg3_read: got %h, expected 0", rd); end
        addr_i = 32'h4;
        #1;
        total++;
        if (data_o !== 32'h0) begin bad++; $display("FAIL deselected_read: got %h, expected 0", data_o); end
    endtask

    task automatic test_divisor_lanes;
        logic [15:0] model;
        logic [31:0] d;
        logic [31:0] rd;
        logic [3:0]  s;
        model = 16'd434;
        for (int t = 0; t < 6; t++) begin
            d = $urandom;
            s = 4'($urandom);
            bus_write(R_DIV, d, s);
            if (s[0]) model[7:0]  = d[7:0];
            if (s[1]) model[15:8] = d[15:8];
            bus_read(R_DIV, rd);
            total++;
            if (rd !== {16'h0, model}) begin
                bad++;
                $display("FAIL divisor_lanes%0d: got %h, expected %h", t, rd, {16'h0, model});
            end
        end
    endtask

    task automatic test_frame;
        int div;
        for (int t = 0; t < 4; t++) begin
            div = (t == 0) ? 4 : (t == 1) ? 0 : $urandom_range(1, 5);
            tx_bytes.delete();
            tx_bytes.push_back((t == 0) ? 8'hA5 : 8'($urandom));
            send_and_check(div, $sformatf("frame%0d_div%0d", t, div));
        end
    endtask

    task automatic test_back_to_back;
        tx_bytes.delete();
        tx_bytes.push_back(8'h01);
        tx_bytes.push_back(8'h02);
        send_and_check(3, "b2b_fixed");
        tx_bytes.delete();
        for (int i = 0; i < 3; i++) tx_bytes.push_back(8'($urandom));
        send_and_check($urandom_range(1, 4), "b2b_random");
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity;
        tx_bytes.delete();
        tx_bytes.push_back(8'h07);
        send_and_check(2, "parity_07");
        tx_bytes.delete();
        tx_bytes.push_back(8'($urandom));
        tx_bytes.push_back(8'($urandom));
        send_and_check($urandom_range(1, 3), "parity_random");
    endtask
`endif

    task automatic test_overflow;
        logic [7:0]  extra[$];
        logic [7:0]  b0;
        logic [31:0] rd;
        b0 = 8'($urandom);
        for (int i = 0; i < 9; i++) extra.push_back(8'($urandom));
        tx_bytes.delete();
        tx_bytes.push_back(b0);
        for (int i = 0; i < 8; i++) tx_bytes.push_back(extra[i]);
        bus_write(R_DIV, 32'd2, 4'b0001);
        build_expected(2);
        bus_write(R_TX, {24'h0, b0}, 4'b0001);
        start_record();
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 9; i++) bus_write(R_TX, {24'($urandom), extra[i]}, 4'b1111);
        bus_read(R_ST, rd);
        total++;
        if (rd !== 32'h8D) begin bad++; $display("FAIL overflow_status1: got %h, expected %h", rd, 32'h8D); end
        bus_read(R_ST, rd);
        total++;
        if (rd !== 32'h85) begin bad++; $display("FAIL overflow_status2: got %h, expected %h", rd, 32'h85); end
        check_stream("overflow_stream");
        bus_read(R_ST, rd);
        total++;
        if (rd !== 32'h2) begin bad++; $display("FAIL overflow_status_end: got %h, expected %h", rd, 32'h2); end
    endtask

    task automatic test_reset_mid_frame;
        logic [31:0] rd;
        bus_write(R_DIV, 32'd4, 4'b0011);
        bus_write(R_TX, {24'h0, 8'($urandom)}, 4'b0001);
        bus_write(R_TX, {24'h0, 8'($urandom)}, 4'b0001);
        repeat (14) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        total++;
        if (txd_o !== 1'b1) begin bad++; $display("FAIL midreset_txd: got %b, expected 1", txd_o); end
        total++;
        if (int_o !== 1'b1) begin bad++; $display("FAIL midreset_int: got %b, expected 1", int_o); end
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
        bus_read(R_ST, rd);
        total++;
        if (rd !== 32'h2) begin bad++; $display("FAIL midreset_status: got %h, expected %h", rd, 32'h2); end
        exp_q.delete();
        exp_int_q.delete();
        for (int k = 0; k < 60; k++) begin
            exp_q.push_back(1'b1);
            exp_int_q.push_back(1'b1);
        end
        start_record();
        check_stream("midreset_quiet");
    endtask

    initial begin
        test_reset();
        test_divisor_lanes();
        test_frame();
        test_back_to_back();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_overflow();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
